// File: rtl/mips_tlb_mmu.sv
// MIPS32 MMU: fixed segment decode plus a fully associative joint TLB shared by
// the instruction and data lookup ports. Lookups, reads and probes are combinational.
module mips_tlb_mmu #(
  parameter int TLB_IDX_BITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    user_mode,
  input  logic                    kseg0_uncached,
  input  logic                    inst_en,
  input  logic [31:0]             iaddr_i,
  input  logic                    data_en,
  input  logic                    data_we,
  input  logic [31:0]             daddr_i,
  output logic [31:0]             iaddr_o,
  output logic [31:0]             daddr_o,
  output logic                    inst_uncached,
  output logic                    data_uncached,
  output logic                    inst_mapped,
  output logic                    data_mapped,
  output logic                    inst_illegal,
  output logic                    data_illegal,
  output logic                    inst_miss,
  output logic                    data_miss,
  output logic                    inst_invalid,
  output logic                    data_invalid,
  output logic                    data_modified,
  input  logic                    tlb_we,
  input  logic [TLB_IDX_BITS-1:0] tlb_index,
  input  logic [15:0]             mask_i,
  input  logic [31:0]             entryhi_i,
  input  logic [31:0]             entrylo0_i,
  input  logic [31:0]             entrylo1_i,
  output logic [15:0]             mask_o,
  output logic [31:0]             entryhi_o,
  output logic [31:0]             entrylo0_o,
  output logic [31:0]             entrylo1_o,
  output logic [31:0]             probe_o
);

  localparam int IW   = TLB_IDX_BITS;
  localparam int NENT = 1 << TLB_IDX_BITS;

  typedef struct packed {
    logic        present;
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [15:0] mask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] pa;
    logic        uncached;
    logic        mapped;
    logic        illegal;
    logic        miss;
    logic        invalid;
    logic        modified;
  } xlate_t;

  tlb_entry_t ent_q [NENT];
  tlb_entry_t ent_d [NENT];

  logic [NENT-1:0] imatch, dmatch, pmatch;
  logic [IW:0]     ihit, dhit, phit;
  xlate_t          ix, dx;
  tlb_entry_t      rd_ent;

  // Reserved register fields are accepted and dropped.
  logic unused_bits;
  assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26]};

  function automatic logic ent_match(input tlb_entry_t e, input logic [18:0] vpn2,
                                     input logic [7:0] asid);
    logic [18:0] m;
    m = ~{3'b000, e.mask};
    return e.present && ((e.vpn2 & m) == (vpn2 & m)) && (e.g || (e.asid == asid));
  endfunction

  // Returns {hit, index}; scanning downwards leaves the lowest matching index.
  function automatic logic [IW:0] first_hit(input logic [NENT-1:0] m);
    logic [IW:0] r;
    r = '0;
    for (int n = NENT - 1; n >= 0; n--) begin
      if (m[n]) r = {1'b1, IW'(n)};
    end
    return r;
  endfunction

  function automatic xlate_t translate(input logic [31:0] va, input logic en,
                                       input logic we, input logic hit,
                                       input tlb_entry_t e, input logic user,
                                       input logic k0_unc);
    xlate_t      x;
    int          k;
    logic        odd;
    logic [19:0] pfn, m20;
    logic [2:0]  c;
    logic        d, v;
    k = 0;
    for (int b = 0; b < 16; b++) k += int'(e.mask[b]);
    odd = va[12+k];
    pfn = odd ? e.pfn1 : e.pfn0;
    c   = odd ? e.c1 : e.c0;
    d   = odd ? e.d1 : e.d0;
    v   = odd ? e.v1 : e.v0;
    m20 = {4'b0000, e.mask};
    x = '0;
    x.mapped  = !(va[31:29] == 3'b100 || va[31:29] == 3'b101);
    x.illegal = en & user & va[31];
    if (!x.mapped) begin
      x.pa       = {3'b000, va[28:0]};
      x.uncached = en & ((va[31:29] == 3'b101) | k0_unc);
    end else if (hit) begin
      x.pa       = {(pfn & ~m20) | (va[31:12] & m20), va[11:0]};
      x.uncached = en & (c == 3'd2);
      x.invalid  = en & ~v;
      x.modified = en & we & v & ~d;
    end else begin
      x.miss = en;
    end
    return x;
  endfunction

  always_comb begin
    for (int n = 0; n < NENT; n++) begin
      imatch[n] = ent_match(ent_q[n], iaddr_i[31:13], entryhi_i[7:0]);
      dmatch[n] = ent_match(ent_q[n], daddr_i[31:13], entryhi_i[7:0]);
      pmatch[n] = ent_match(ent_q[n], entryhi_i[31:13], entryhi_i[7:0]);
    end
    ihit = first_hit(imatch);
    dhit = first_hit(dmatch);
    phit = first_hit(pmatch);
    ix = translate(iaddr_i, inst_en, 1'b0, ihit[IW], ent_q[ihit[IW-1:0]],
                   user_mode, kseg0_uncached);
    dx = translate(daddr_i, data_en, data_we, dhit[IW], ent_q[dhit[IW-1:0]],
                   user_mode, kseg0_uncached);
  end

  assign iaddr_o       = ix.pa;
  assign inst_uncached = ix.uncached;
  assign inst_mapped   = ix.mapped;
  assign inst_illegal  = ix.illegal;
  assign inst_miss     = ix.miss;
  assign inst_invalid  = ix.invalid;
  assign daddr_o       = dx.pa;
  assign data_uncached = dx.uncached;
  assign data_mapped   = dx.mapped;
  assign data_illegal  = dx.illegal;
  assign data_miss     = dx.miss;
  assign data_invalid  = dx.invalid;
  assign data_modified = dx.modified;

  assign probe_o = phit[IW] ? {{(32-IW){1'b0}}, phit[IW-1:0]} : 32'h8000_0000;

  always_comb begin
    rd_ent = ent_q[tlb_index];
    if (!rd_ent.present) rd_ent = '0;
  end

  assign mask_o     = rd_ent.mask;
  assign entryhi_o  = {rd_ent.vpn2, 5'b00000, rd_ent.asid};
  assign entrylo0_o = {6'b000000, rd_ent.pfn0, rd_ent.c0, rd_ent.d0, rd_ent.v0, rd_ent.g};
  assign entrylo1_o = {6'b000000, rd_ent.pfn1, rd_ent.c1, rd_ent.d1, rd_ent.v1, rd_ent.g};

  always_comb begin
    for (int n = 0; n < NENT; n++) ent_d[n] = ent_q[n];
    if (tlb_we) begin
      ent_d[tlb_index] = '{
        present: 1'b1,
        vpn2:    entryhi_i[31:13],
        asid:    entryhi_i[7:0],
        mask:    mask_i,
        g:       entrylo0_i[0] & entrylo1_i[0],
        pfn0:    entrylo0_i[25:6],
        c0:      entrylo0_i[5:3],
        d0:      entrylo0_i[2],
        v0:      entrylo0_i[1],
        pfn1:    entrylo1_i[25:6],
        c1:      entrylo1_i[5:3],
        d1:      entrylo1_i[2],
        v1:      entrylo1_i[1]
      };
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < NENT; n++) begin
      if (rst) ent_q[n] <= '0;
      else     ent_q[n] <= ent_d[n];
    end
  end

endmodule

// File: tb/tb_mips_tlb_mmu.sv
// Directed bench for mips_tlb_mmu: stimulus queues expected values, a monitor
// compares them against the DUT outputs on the falling edge.
module tb_mips_tlb_mmu;

  logic        clk = 1'b0;
  logic        rst, user_mode, kseg0_uncached;
  logic        inst_en, data_en, data_we, tlb_we;
  logic [31:0] iaddr_i, daddr_i, iaddr_o, daddr_o;
  logic        inst_uncached, data_uncached, inst_mapped, data_mapped;
  logic        inst_illegal, data_illegal, inst_miss, data_miss;
  logic        inst_invalid, data_invalid, data_modified;
  logic [4:0]  tlb_index;
  logic [15:0] mask_i, mask_o;
  logic [31:0] entryhi_i, entrylo0_i, entrylo1_i;
  logic [31:0] entryhi_o, entrylo0_o, entrylo1_o, probe_o;

  mips_tlb_mmu #(.TLB_IDX_BITS(5)) dut (
    .clk(clk), .rst(rst), .user_mode(user_mode), .kseg0_uncached(kseg0_uncached),
    .inst_en(inst_en), .iaddr_i(iaddr_i), .data_en(data_en), .data_we(data_we),
    .daddr_i(daddr_i), .iaddr_o(iaddr_o), .daddr_o(daddr_o),
    .inst_uncached(inst_uncached), .data_uncached(data_uncached),
    .inst_mapped(inst_mapped), .data_mapped(data_mapped),
    .inst_illegal(inst_illegal), .data_illegal(data_illegal),
    .inst_miss(inst_miss), .data_miss(data_miss),
    .inst_invalid(inst_invalid), .data_invalid(data_invalid),
    .data_modified(data_modified), .tlb_we(tlb_we), .tlb_index(tlb_index),
    .mask_i(mask_i), .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i),
    .entrylo1_i(entrylo1_i), .mask_o(mask_o), .entryhi_o(entryhi_o),
    .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o), .probe_o(probe_o)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_DPA, S_DUNC, S_DMAP, S_DILL, S_DMISS, S_DINV, S_DMOD,
    S_IPA, S_IUNC, S_IMAP, S_IMISS, S_PROBE, S_EHI, S_ELO0, S_ELO1, S_MASK
  } sel_t;

  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  logic chk_req = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(input sel_t s);
    case (s)
      S_DPA:   return daddr_o;
      S_DUNC:  return {31'b0, data_uncached};
      S_DMAP:  return {31'b0, data_mapped};
      S_DILL:  return {31'b0, data_illegal};
      S_DMISS: return {31'b0, data_miss};
      S_DINV:  return {31'b0, data_invalid};
      S_DMOD:  return {31'b0, data_modified};
      S_IPA:   return iaddr_o;
      S_IUNC:  return {31'b0, inst_uncached};
      S_IMAP:  return {31'b0, inst_mapped};
      S_IMISS: return {31'b0, inst_miss};
      S_PROBE: return probe_o;
      S_EHI:   return entryhi_o;
      S_ELO0:  return entrylo0_o;
      S_ELO1:  return entrylo1_o;
      default: return {16'b0, mask_o};
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_req) begin
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = observe(e.sel);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input string n, input sel_t s, input logic [31:0] v);
    sb.push_back('{name: n, sel: s, exp: v});
  endtask

  task automatic check_now();
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic tlb_write(input logic [4:0] idx, input logic [31:0] hi,
                           input logic [31:0] lo0, input logic [31:0] lo1,
                           input logic [15:0] m);
    tlb_index = idx; entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1; mask_i = m;
    tlb_we = 1'b1;
    @(posedge clk); #1;
    tlb_we = 1'b0;
    mask_i = 16'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; user_mode = 1'b0; kseg0_uncached = 1'b0;
    inst_en = 1'b1; data_en = 1'b1; data_we = 1'b0; tlb_we = 1'b0;
    iaddr_i = 32'h0; daddr_i = 32'h0; tlb_index = 5'd0; mask_i = 16'h0;
    entryhi_i = 32'h0; entrylo0_i = 32'h0; entrylo1_i = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and unmapped segments
    tlb_index = 5'd3;
    expect_v("rst_read_hi", S_EHI, 32'h0);
    expect_v("rst_read_lo0", S_ELO0, 32'h0);
    daddr_i = 32'h8000_1234;
    iaddr_i = 32'hBFC0_0000;
    expect_v("kseg0_pa", S_DPA, 32'h0000_1234);
    expect_v("kseg0_cached", S_DUNC, 32'h0);
    expect_v("kseg0_unmapped", S_DMAP, 32'h0);
    expect_v("kseg1_pa", S_IPA, 32'h1FC0_0000);
    expect_v("kseg1_uncached", S_IUNC, 32'h1);
    check_now();
    kseg0_uncached = 1'b1;
    expect_v("kseg0_k0_uncached", S_DUNC, 32'h1);
    check_now();
    kseg0_uncached = 1'b0;

    // Mapped miss after reset, probe miss
    iaddr_i = 32'h0040_0000;
    entryhi_i = 32'h0040_0005;
    expect_v("kuseg_mapped", S_IMAP, 32'h1);
    expect_v("kuseg_miss", S_IMISS, 32'h1);
    expect_v("miss_pa_zero", S_IPA, 32'h0);
    expect_v("probe_miss", S_PROBE, 32'h8000_0000);
    check_now();

    // Basic entry: index 3, even page valid, odd page invalid
    tlb_write(5'd3, 32'h0040_0005, 32'h0048_D15E, 32'h0, 16'h0);
    daddr_i = 32'h0040_0ABC;
    expect_v("hit_pa", S_DPA, 32'h1234_5ABC);
    expect_v("hit_no_miss", S_DMISS, 32'h0);
    expect_v("hit_no_inv", S_DINV, 32'h0);
    expect_v("hit_cached", S_DUNC, 32'h0);
    expect_v("probe_hit3", S_PROBE, 32'h3);
    expect_v("read_hi", S_EHI, 32'h0040_0005);
    expect_v("read_lo0", S_ELO0, 32'h0048_D15E);
    expect_v("read_lo1", S_ELO1, 32'h0);
    expect_v("read_mask", S_MASK, 32'h0);
    check_now();
    daddr_i = 32'h0040_1ABC;
    expect_v("odd_invalid", S_DINV, 32'h1);
    check_now();

    // ASID mismatch, then global entry
    entryhi_i = 32'h0040_0006;
    daddr_i = 32'h0040_0ABC;
    expect_v("asid_miss", S_DMISS, 32'h1);
    expect_v("asid_miss_pa", S_DPA, 32'h0);
    check_now();
    tlb_write(5'd3, 32'h0040_0006, 32'h0048_D15F, 32'h0000_0001, 16'h0);
    entryhi_i = 32'h0040_0006;
    iaddr_i = 32'h0040_0ABC;
    expect_v("global_hit_pa", S_DPA, 32'h1234_5ABC);
    expect_v("global_no_miss", S_DMISS, 32'h0);
    expect_v("global_inst_pa", S_IPA, 32'h1234_5ABC);
    expect_v("global_read_lo1", S_ELO1, 32'h0000_0001);
    check_now();
    entryhi_i = 32'h0000_0009;
    expect_v("global_other_asid", S_DMISS, 32'h0);
    check_now();

    // Dirty and cacheability flags
    tlb_write(5'd4, 32'h0080_0006, 32'h0002_AF1A, 32'h0002_AF56, 16'h0);
    daddr_i = 32'h0080_0010;
    data_we = 1'b1;
    expect_v("store_modified", S_DMOD, 32'h1);
    expect_v("store_pa", S_DPA, 32'h00AB_C010);
    check_now();
    data_we = 1'b0;
    expect_v("load_not_modified", S_DMOD, 32'h0);
    check_now();
    daddr_i = 32'h0080_1010;
    expect_v("c2_uncached", S_DUNC, 32'h1);
    expect_v("c2_pa", S_DPA, 32'h00AB_D010);
    check_now();

    // Lookup during the write cycle sees the old contents
    tlb_index = 5'd6; entryhi_i = 32'h00C0_0006;
    entrylo0_i = 32'h0000_155E; entrylo1_i = 32'h0; mask_i = 16'h0;
    daddr_i = 32'h00C0_0000;
    tlb_we = 1'b1;
    expect_v("write_cycle_old", S_DMISS, 32'h1);
    expect_v("write_cycle_read_old", S_EHI, 32'h0);
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
    tlb_we = 1'b0;
    expect_v("after_write_hit", S_DMISS, 32'h0);
    expect_v("after_write_pa", S_DPA, 32'h0005_5000);
    check_now();

    // 16 KB pages: select bit va[14], va[13:12] pass through
    tlb_write(5'd7, 32'h0100_0006, 32'h0000_401E, 32'h0000_801E, 16'h0003);
    tlb_index = 5'd7;
    daddr_i = 32'h0100_3ABC;
    expect_v("mask_even_pa", S_DPA, 32'h0010_3ABC);
    expect_v("mask_read", S_MASK, 32'h0003);
    check_now();
    daddr_i = 32'h0100_4ABC;
    expect_v("mask_odd_pa", S_DPA, 32'h0020_0ABC);
    check_now();

    // User-mode address error, qualified by enable
    user_mode = 1'b1;
    daddr_i = 32'h8000_0000;
    expect_v("user_illegal", S_DILL, 32'h1);
    check_now();
    data_en = 1'b0;
    expect_v("user_illegal_noen", S_DILL, 32'h0);
    check_now();
    data_en = 1'b1;

    // Duplicate matches: lowest index wins
    tlb_write(5'd5, 32'h0200_0006, 32'h0001_555E, 32'h0, 16'h0);
    tlb_write(5'd2, 32'h0200_0006, 32'h0000_889E, 32'h0, 16'h0);
    daddr_i = 32'h0200_0123;
    expect_v("dup_pa", S_DPA, 32'h0022_2123);
    expect_v("dup_legal", S_DILL, 32'h0);
    expect_v("dup_probe", S_PROBE, 32'h2);
    check_now();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_tlb_mmu.md
Name: mips_tlb_mmu

Overview:
- MIPS32 address-translation unit combining fixed segment decode (kuseg/kseg0/kseg1/kseg2-3) with a fully associative joint TLB.
- Two lookup ports: instruction fetch and data access.
- Sits between the pipeline address paths and the caches, under CP0 control.
- Lookups are combinational; TLB maintenance (write, read, probe) is driven from CP0 EntryHi/EntryLo0/EntryLo1/PageMask/Index values.

Parameters:
TLB_IDX_BITS, 5, index width; the TLB has 2**TLB_IDX_BITS entries (32).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
user_mode  in  1  1 = user mode; kernel segments are illegal
kseg0_uncached  in  1  1 = kseg0 treated as uncached (Config.K0)
inst_en  in  1  instruction access valid
iaddr_i  in  32  instruction virtual address
data_en  in  1  data access valid
data_we  in  1  data access is a store
daddr_i  in  32  data virtual address
iaddr_o  out  32  instruction physical address
daddr_o  out  32  data physical address
inst_uncached / data_uncached  out  1  access must bypass cache
inst_mapped / data_mapped  out  1  address lies in a TLB-mapped segment
inst_illegal / data_illegal  out  1  address error (user access to va[31]=1)
inst_miss / data_miss  out  1  mapped access, no TLB match
inst_invalid / data_invalid  out  1  mapped access, matched page V=0
data_modified  out  1  mapped store to a valid page with D=0
tlb_we  in  1  write entry tlb_index (TLBWI/TLBWR)
tlb_index  in  TLB_IDX_BITS  entry for write and read
mask_i  in  16  PageMask[28:13]
entryhi_i  in  32  {VPN2[31:13], 5'b0, ASID[7:0]}; ASID is also the current ASID for lookups
entrylo0_i / entrylo1_i  in  32  {6'b0, PFN[25:6], C[5:3], D[2], V[1], G[0]}
mask_o  out  16  PageMask of entry tlb_index
entryhi_o / entrylo0_o / entrylo1_o  out  32  entry tlb_index, same formats; unused bits read 0
probe_o  out  32  probe result of entryhi_i: bit31 = 1 on no match, else index in low bits; all other bits 0

Behaviour:
- Segments, by va[31:29]:
  - 0xx kuseg: mapped.
  - 100 kseg0: pa = va & 0x1FFF_FFFF; uncached = kseg0_uncached.
  - 101 kseg1: pa = va & 0x1FFF_FFFF; always uncached.
  - 11x kseg2/3: mapped.
- Illegal: illegal = en & user_mode & va[31]. Illegal does not suppress the other outputs; the consumer prioritises.
- Entry state:
  - Each entry stores a present bit, VPN2[18:0], ASID, mask[15:0], G, and per-half PFN/C/D/V.
  - Reset clears every present bit and zeroes all fields.
  - Non-present entries never match and read back as all zero.
- Write (tlb_we on clock edge):
  - Load the entry at tlb_index and set present.
  - G = entrylo0_i[0] & entrylo1_i[0]. The same G is returned in both entrylo outputs.
  - Lookups and reads in the write cycle see the old contents; new contents are visible the next cycle.
- Match rule:
  - VPN2 condition: (entry.VPN2 & ~{3'b0,mask}) == (va[31:13] & ~{3'b0,mask}).
  - ASID condition: (entry.G | entry.ASID == entryhi_i[7:0]).
  - Multiple matches: the lowest index wins.
- Even/odd select bit:
  - va[12] when mask = 0.
  - Otherwise va[12+k], where k is the number of set mask bits.
  - Only contiguous-from-LSB, even-width masks are legal; other masks are undefined.
- Mapped physical address: pa[31:12] = PFN, with the bits covered by the mask (pa[12+k-1:12]) taken from va; pa[11:0] = va[11:0].
- Flags (each qualified by en, and mapped where applicable):
  - miss = no match.
  - invalid = match & ~V.
  - modified = data_we & match & V & ~D.
  - uncached = (C == 3'd2).
- Miss outputs: when a mapped access misses, pa = 0 and uncached = 0.
- Reads: combinational from tlb_index.
- Probe: combinational, using entryhi_i VPN2/ASID; the probe ignores its odd/even bit.
- en = 0: all exception flags are 0; address outputs still reflect the translation.

Test Plan:
1. After reset, kernel mode: daddr_i 0x8000_1234 -> daddr_o 0x0000_1234, uncached 0, mapped 0. With kseg0_uncached=1 -> uncached 1. iaddr_i 0xBFC0_0000 -> 0x1FC0_0000, uncached 1.
2. After reset: iaddr_i 0x0040_0000 -> inst_mapped 1, inst_miss 1. Probe with entryhi_i 0x0040_0005 -> probe_o 0x8000_0000.
3. Write index 3 with entryhi 0x0040_0005, lo0 0x0048_D15E (PFN 0x12345, C3, D1, V1), lo1 0, mask 0:
   - daddr 0x0040_0ABC -> 0x1234_5ABC, no flags.
   - daddr 0x0040_1ABC -> data_invalid 1.
   - probe_o 0x0000_0003.
   - Read index 3 returns the written values, with G=0 in both entrylo outputs.
4. Change entryhi_i ASID to 6 -> data_miss 1. Rewrite index 3 with G=1 in both lo -> hit again with ASID 6.
5. Page with D=0, store -> data_modified 1; load -> 0. Page with C=2 -> data_uncached 1. Lookup in the same cycle as tlb_we returns the old result.
6. user_mode=1: daddr 0x8000_0000 -> data_illegal 1; same with data_en=0 -> 0. Duplicate matches in entries 2 and 5 -> entry 2 used; probe returns 2.
